// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg
// Shared definitions for the PS/2 keyboard port: frame-state codes, the CPU
// address offsets, status-word bit positions, the break prefix byte and the
// width of a buffered scan-code entry.
// Build option: PS2_BREAK_DECODE_EN widens each entry to 9 bits so that a
// break flag can travel with its byte.
package ps2_key_pkg;

    // Frame receiver states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // CPU-visible word offsets
    localparam logic DATA_ADDR   = 1'b0;
    localparam logic STATUS_ADDR = 1'b1;

    // Status word layout
    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_COUNT_LSB = 8;

    // Keyboard prefix announcing a key release
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

`ifdef PS2_BREAK_DECODE_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif

    // PS/2 uses odd parity over the eight data bits plus the parity bit
    function automatic logic frame_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_key_port_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a show-ahead head: 'head' always shows the oldest
// entry while the FIFO is not empty.
// Ports: clock, reset (async, active-low), push/push_data, pop, head, count,
// full, empty. A pop on an empty FIFO is ignored; a push while full is
// ignored unless a pop in the same cycle frees the slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ps2_key_port.sv
// ps2_key_port
// Memory-mapped PS/2 keyboard peripheral. Deserialises PS/2 frames, buffers
// scan codes in a FIFO and presents data/status words to CPU loads.
// Ports:
//   clock, reset (async, active-low)
//   ps2_clk, ps2_data  raw asynchronous PS/2 pins
//   read_en, read_addr CPU load strobe and word select (0 data, 1 status)
//   read_data          combinational view of the selected word
//   irq, reset_irq     level interrupt and its clear
// Build option: PS2_BREAK_DECODE_EN folds the 0xF0 prefix into bit 9 of the
// following data word instead of buffering it.
module ps2_key_port
    import ps2_key_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        read_en,
    input  logic        read_addr,
    output logic [15:0] read_data,
    output logic        irq,
    input  logic        reset_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic               clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic               dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic               filt_clk_q, filt_clk_d;
    logic [FW-1:0]      filt_cnt_q, filt_cnt_d;
    logic               strobe_q, strobe_d;
    logic [1:0]         state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_q, parity_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               push_q, push_d;
    logic [ENTRY_W-1:0] push_data_q, push_data_d;
    logic               overflow_q, overflow_d;
    logic               frame_err_q, frame_err_d;
    logic               irq_q, irq_d;
`ifdef PS2_BREAK_DECODE_EN
    logic               brk_pending_q, brk_pending_d;
`endif

    logic               frame_ok, frame_bad;
    logic               data_rd, status_rd;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty;
    logic [7:0]         count_byte;
    logic [15:0]        data_word, status_word;

    assign data_rd   = read_en && (read_addr == DATA_ADDR);
    assign status_rd = read_en && (read_addr == STATUS_ADDR);
    assign irq       = irq_q;

    // Pin synchronisers plus the glitch filter on ps2_clk. The filtered clock
    // only follows the pin after FILTER_LEN consecutive differing samples, and
    // its falling edge becomes a registered one-cycle strobe.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        strobe_d = filt_clk_q && !filt_clk_d;
    end

    // Frame receiver. The inactivity counter only runs mid-frame; expiry
    // abandons the partial frame and counts as a frame error.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = '0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe_q && !dat_s2_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (strobe_q) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (strobe_q) begin
                    parity_d = dat_s2_q;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (strobe_q) begin
                    if (dat_s2_q && frame_parity_ok(shift_q, parity_q)) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !strobe_q) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                state_d   = ST_IDLE;
                frame_bad = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // Accepted bytes are registered and pushed one cycle later. With break
    // decoding, the 0xF0 prefix is absorbed into a pending flag that tags the
    // next byte; any frame error forgets a pending prefix.
    always_comb begin
        push_d      = 1'b0;
        push_data_d = push_data_q;
`ifdef PS2_BREAK_DECODE_EN
        brk_pending_d = brk_pending_q;
        if (frame_ok) begin
            if (shift_q == BREAK_PREFIX) begin
                brk_pending_d = 1'b1;
            end else begin
                push_d        = 1'b1;
                push_data_d   = {brk_pending_q, shift_q};
                brk_pending_d = 1'b0;
            end
        end
        if (frame_bad) begin
            brk_pending_d = 1'b0;
        end
`else
        if (frame_ok) begin
            push_d      = 1'b1;
            push_data_d = shift_q;
        end
`endif
    end

    // Sticky flags: a status read clears them, but an error in the same
    // cycle keeps them set. A full FIFO being popped is never an overflow.
    always_comb begin
        overflow_d  = (push_q && fifo_full && !data_rd) || (overflow_q && !status_rd);
        frame_err_d = frame_bad || (frame_err_q && !status_rd);
        if (push_q) begin
            irq_d = 1'b1;
        end else if (reset_irq) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // CPU-visible words
    always_comb begin
        count_byte            = '0;
        count_byte[CW-1:0]    = fifo_count;
        status_word           = '0;
        status_word[15:STAT_COUNT_LSB] = count_byte;
        status_word[STAT_FRAME_ERR]    = frame_err_q;
        status_word[STAT_OVERFLOW]     = overflow_q;
        status_word[STAT_FULL]         = fifo_full;
        status_word[STAT_NOT_EMPTY]    = !fifo_empty;
`ifdef PS2_BREAK_DECODE_EN
        data_word = fifo_empty ? 16'h0000 : {6'b0, fifo_head[8], 1'b1, fifo_head[7:0]};
`else
        data_word = fifo_empty ? 16'h0000 : {7'b0, 1'b1, fifo_head};
`endif
        read_data = (read_addr == STATUS_ADDR) ? status_word : data_word;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            strobe_q    <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
            brk_pending_q <= 1'b0;
`endif
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            strobe_q    <= strobe_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
`ifdef PS2_BREAK_DECODE_EN
            brk_pending_q <= brk_pending_d;
`endif
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (data_rd),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_key_port.sv
// tb_ps2_key_port
// Self-checking bench for ps2_key_port. Frames are driven bit by bit on the
// PS/2 pins and a byte-level model (queue of scan codes plus flag bits)
// predicts every data/status word and the irq level.
// Build option: PS2_BREAK_DECODE_EN selects the break-decoding expectations.
module tb_ps2_key_port;
    localparam int HALF  = 20;
    localparam int TMO   = 1000;
    localparam int DEPTH = 16;
`ifdef PS2_BREAK_DECODE_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        read_en = 1'b0;
    logic        read_addr = 1'b0;
    logic        reset_irq = 1'b0;
    logic [15:0] read_data;
    logic        irq;

    int total = 0;
    int bad = 0;

    // Byte-level model state
    logic [8:0] exp_q[$];
    bit exp_ovf, exp_ferr, exp_irq, exp_pend;

    always #5 clock = ~clock;

    ps2_key_port #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .read_en   (read_en),
        .read_addr (read_addr),
        .read_data (read_data),
        .irq       (irq),
        .reset_irq (reset_irq)
    );

    // Model
    task automatic model_reset();
        exp_q.delete();
        exp_ovf  = 0;
        exp_ferr = 0;
        exp_irq  = 0;
        exp_pend = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_ferr = 1;
            exp_pend = 0;
        end else if (BRK && b == 8'hF0) begin
            exp_pend = 1;
        end else begin
            if (exp_q.size() == DEPTH) exp_ovf = 1;
            else exp_q.push_back({exp_pend, b});
            exp_pend = 0;
            exp_irq  = 1;
        end
    endtask

    function automatic logic [15:0] exp_data();
        if (exp_q.size() == 0) return 16'h0000;
        return {6'b0, exp_q[0][8], 1'b1, exp_q[0][7:0]};
    endfunction

    function automatic logic [15:0] exp_status();
        logic [7:0] c;
        c = 8'(exp_q.size());
        return {c, 4'b0, exp_ferr, exp_ovf, exp_q.size() == DEPTH, exp_q.size() != 0};
    endfunction

    task automatic model_read(input logic a);
        if (a == 1'b0) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            exp_ovf  = 0;
            exp_ferr = 0;
        end
    endtask

    // Stimulus helpers
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good_parity, input bit good_stop);
        logic p;
        logic [10:0] f;
        p = ~^b;
        if (!good_parity) p = ~p;
        f = {good_stop, p, b, 1'b0};
        send_bits(f, 11);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
        model_frame(b, good_parity && good_stop);
    endtask

    task automatic read_word(input logic a, output logic [15:0] d);
        @(negedge clock);
        read_addr = a;
        read_en   = 1'b1;
        #1 d = read_data;
        @(negedge clock);
        read_en = 1'b0;
        model_read(a);
    endtask

    task automatic clear_irq();
        @(negedge clock);
        reset_irq = 1'b1;
        @(negedge clock);
        reset_irq = 1'b0;
        exp_irq = 0;
    endtask

    // Tests
    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clock);
        read_addr = 1'b0;
        #1;
        total++;
        if (read_data !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_data got=%h want=0000", read_data);
        end
        read_addr = 1'b1;
        #1;
        total++;
        if (read_data !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_status got=%h want=0000", read_data);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_irq got=%b want=0", irq);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single_frame();
        logic [15:0] d;
        send_frame(8'h1C, 1, 1);
        #1;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_irq got=%b want=1", irq);
        end
        read_word(1'b1, d);
        total++;
        if (d !== 16'h0101) begin
            bad++;
            $display("[TB] FAIL single_status got=%h want=0101", d);
        end
        read_word(1'b0, d);
        total++;
        if (d !== 16'h011C) begin
            bad++;
            $display("[TB] FAIL single_data got=%h want=011c", d);
        end
        read_word(1'b1, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL single_status_after got=%h want=0000", d);
        end
        clear_irq();
    endtask

    task automatic test_parity_error();
        logic [15:0] d;
        send_frame(8'h1C, 0, 1);
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL parity_irq got=%b want=0", irq);
        end
        read_word(1'b1, d);
        total++;
        if (d !== 16'h0008) begin
            bad++;
            $display("[TB] FAIL parity_status got=%h want=0008", d);
        end
        read_word(1'b1, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL parity_cleared got=%h want=0000", d);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1, 1);
        read_word(1'b1, d);
        total++;
        if (d !== 16'h1007) begin
            bad++;
            $display("[TB] FAIL overflow_status got=%h want=1007", d);
        end
        for (int i = 1; i <= 16; i++) begin
            read_word(1'b0, d);
            total++;
            if (d !== (16'h0100 | 16'(i))) begin
                bad++;
                $display("[TB] FAIL overflow_drain%0d got=%h want=%h", i, d, 16'h0100 | 16'(i));
            end
        end
        read_word(1'b0, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL overflow_empty got=%h want=0000", d);
        end
        clear_irq();
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        // start bit then the low nibble of 0x1C, then the clock stalls high
        send_bits(11'b000_0001_1000, 5);
        ps2_data = 1'b1;
        repeat (TMO + 100) @(negedge clock);
        exp_ferr = 1;
        exp_pend = 0;
        read_word(1'b1, d);
        total++;
        if (d !== 16'h0008) begin
            bad++;
            $display("[TB] FAIL timeout_status got=%h want=0008", d);
        end
        send_frame(8'h1C, 1, 1);
        read_word(1'b0, d);
        total++;
        if (d !== 16'h011C) begin
            bad++;
            $display("[TB] FAIL timeout_next_data got=%h want=011c", d);
        end
        read_word(1'b1, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL timeout_final_status got=%h want=0000", d);
        end
        clear_irq();
    endtask

    task automatic test_irq_push_wins();
        logic [15:0] d;
        logic [10:0] f;
        bit seen;
        f = {1'b1, ~^8'h33, 8'h33, 1'b0};
        send_bits(f, 10);
        // stop bit: hold reset_irq high across the whole push window
        @(negedge clock);
        reset_irq = 1'b1;
        ps2_data  = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 * HALF && !seen; i++) begin
            @(posedge clock);
            #1;
            if (irq === 1'b1) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL irq_push_wins got=0 want=1");
        end
        @(posedge clock);
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL irq_cleared got=%b want=0", irq);
        end
        reset_irq = 1'b0;
        @(negedge clock);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clock);
        model_frame(8'h33, 1);
        exp_irq = 0;
        read_word(1'b0, d);
        total++;
        if (d !== 16'h0133) begin
            bad++;
            $display("[TB] FAIL irq_frame_data got=%h want=0133", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        send_bits(11'b000_0001_0110, 4);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        send_frame(8'h5A, 1, 1);
        read_word(1'b1, d);
        total++;
        if (d !== 16'h0101) begin
            bad++;
            $display("[TB] FAIL midreset_status got=%h want=0101", d);
        end
        read_word(1'b0, d);
        total++;
        if (d !== 16'h015A) begin
            bad++;
            $display("[TB] FAIL midreset_data got=%h want=015a", d);
        end
        clear_irq();
    endtask

    task automatic test_break();
        logic [15:0] d;
        send_frame(8'hF0, 1, 1);
        send_frame(8'h1C, 1, 1);
        read_word(1'b1, d);
        total++;
        if (d !== (BRK ? 16'h0101 : 16'h0201)) begin
            bad++;
            $display("[TB] FAIL break_status got=%h want=%h", d, BRK ? 16'h0101 : 16'h0201);
        end
        read_word(1'b0, d);
        total++;
        if (d !== (BRK ? 16'h031C : 16'h01F0)) begin
            bad++;
            $display("[TB] FAIL break_data got=%h want=%h", d, BRK ? 16'h031C : 16'h01F0);
        end
        // a bad frame after the prefix discards it
        send_frame(8'hF0, 1, 1);
        send_frame(8'h22, 1, 0);
        send_frame(8'h1C, 1, 1);
        while (exp_q.size() > 1) read_word(1'b0, d);
        read_word(1'b0, d);
        total++;
        if (d !== 16'h011C) begin
            bad++;
            $display("[TB] FAIL break_cleared_data got=%h want=011c", d);
        end
        read_word(1'b1, d);
        clear_irq();
    endtask

    task automatic test_random();
        logic [15:0] d, e;
        logic [7:0] b;
        bit gp, gs;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) b = 8'hF0;
            gp = ($urandom_range(0, 5) != 0);
            gs = ($urandom_range(0, 7) != 0);
            send_frame(b, gp, gs);
            #1;
            total++;
            if (irq !== exp_irq) begin
                bad++;
                $display("[TB] FAIL rand_irq%0d got=%b want=%b", n, irq, exp_irq);
            end
            if (exp_q.size() >= 10 || $urandom_range(0, 1) == 1) begin
                e = exp_data();
                read_word(1'b0, d);
                total++;
                if (d !== e) begin
                    bad++;
                    $display("[TB] FAIL rand_data%0d got=%h want=%h", n, d, e);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                e = exp_status();
                read_word(1'b1, d);
                total++;
                if (d !== e) begin
                    bad++;
                    $display("[TB] FAIL rand_status%0d got=%h want=%h", n, d, e);
                end
            end
            if ($urandom_range(0, 3) == 0) clear_irq();
        end
        e = exp_status();
        read_word(1'b1, d);
        total++;
        if (d !== e) begin
            bad++;
            $display("[TB] FAIL rand_final_status got=%h want=%h", d, e);
        end
        for (int k = 0; k < DEPTH + 1; k++) begin
            e = exp_data();
            read_word(1'b0, d);
            total++;
            if (d !== e) begin
                bad++;
                $display("[TB] FAIL rand_drain%0d got=%h want=%h", k, d, e);
            end
        end
        clear_irq();
    endtask

    initial begin
        $display("[TB] ps2_key_port bench start (break decode=%0d)", BRK);
        test_reset();
        test_single_frame();
        test_parity_error();
        test_overflow();
        test_timeout();
        test_irq_push_wins();
        test_reset_mid_frame();
        test_break();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_port.md
Name: ps2_key_port

Overview:
- Memory-mapped PS/2 keyboard peripheral that feeds the datapath's keyboard I/O port through memory_control.
- Deserialises PS/2 frames and buffers scan codes in a FIFO.
- Exposes a data word and a status word to CPU loads.
- Raises an interrupt for the datapath's IRQ path; the CPU clears it through the reset_irq control signal.

Parameters:
- FIFO_DEPTH, 16, scan-code entries buffered; power of two, 2..128.
- FILTER_LEN, 8, consecutive equal samples needed to accept a ps2_clk level change.
- TIMEOUT_CYCLES, 50000, clocks without a ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- read_en  in  1  CPU load strobe for this peripheral, one cycle per access.
- read_addr  in  1  0 = data word, 1 = status word.
- read_data  out  16  combinational view of the selected word.
- irq  out  1  level interrupt request.
- reset_irq  in  1  clears irq.

Behaviour:
- Synchronise both pins through 2 flops.
- Filter ps2_clk: the filtered level changes only after FILTER_LEN consecutive equal samples.
- A falling edge of the filtered clock produces a one-cycle sample strobe; ps2_data (synchronised) is sampled on that strobe.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on strobe, if data=0 (start bit) go to DATA with bit counter=0; otherwise stay in IDLE.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: on strobe, accept the frame if stop=1 and the total number of 1s in 8 data bits plus parity bit is odd; otherwise set sticky frame_err and drop the frame. Return to IDLE.
- Timeout: in any state other than IDLE, a cycle counter is cleared on each strobe. When it reaches TIMEOUT_CYCLES, go to IDLE, set frame_err, drop the partial frame.
- Accepted byte is pushed into the FIFO in the cycle after the STOP strobe.
- FIFO full at push time: the byte is dropped and sticky overflow is set. Exception: a simultaneous pop frees a slot, so the push is accepted.
- Data word (read_addr=0):
  - Not empty: {7'b0, 1'b1, head_byte}.
  - Empty: 16'h0000.
  - read_en with addr 0 and FIFO not empty pops at the clock edge; popping when empty is a no-op.
- Status word (read_addr=1): {count[7:0], 4'b0, frame_err, overflow, full, not_empty}.
  - read_en with addr 1 clears overflow and frame_err at the clock edge, after the current value has been presented.
  - An error event in the same cycle as the clear wins, and the flag stays set.
- Simultaneous push and pop: count is unchanged and both operations take effect.
- irq:
  - Set in the cycle after any FIFO push.
  - Held until reset_irq is sampled high.
  - reset_irq coinciding with a push leaves irq=1 (push wins).
- Reset values: FSM=IDLE, FIFO empty, count=0, flags=0, irq=0, filtered clock=1. read_data therefore reads 0 on both addresses.
- Reset mid-frame discards the partial frame.

Optional Feature:
- Macro PS2_BREAK_DECODE_EN.
- Defined:
  - An accepted 0xF0 byte is not pushed; it sets a pending-break flag.
  - The next accepted byte is pushed with data-word bit 9 = 1, and the pending flag is then cleared.
  - FIFO entries are 9 bits wide.
  - A frame error or timeout while break is pending clears the pending flag.
- Not defined: all bytes, including 0xF0, are pushed raw; data-word bit 9 is always 0; FIFO entries are 8 bits wide.

Decomposition:
- Package ps2_key_pkg holds:
  - Frame-state enum (IDLE, DATA, PARITY, STOP).
  - Address offsets DATA_ADDR=0 and STATUS_ADDR=1.
  - Status bit positions.
  - Break prefix constant 8'hF0.
- Sub-module sync_fifo (parameterised width/depth; push, pop, head, count, full, empty; show-ahead head).

Test Plan:
- Send frame for 0x1C (parity bit 0, stop 1) -> status=16'h0101, irq=1, data read returns 16'h011C; a later status read returns 16'h0000.
- Send 0x1C with parity bit 1 -> nothing pushed, status bit 3 set, irq stays 0; a status read clears it.
- Fill the FIFO with 17 bytes 0x01..0x11 and no reads -> count=16, full=1, overflow=1; reads return 0x01..0x10 in order, then 16'h0000.
- Start a frame, send 4 data bits, stall ps2_clk high for TIMEOUT_CYCLES -> frame_err=1, FSM back in IDLE; a following valid 0x1C frame is pushed correctly.
- Assert reset_irq in the same cycle as a push -> irq remains 1; assert reset_irq alone -> irq=0 on the next cycle.
- With PS2_BREAK_DECODE_EN, send 0xF0 then 0x1C -> single entry; data read returns 16'h031C.
